// File: rtl/postage_filter_hls_deadlock_reporter.sv
// Qualifies a persistent, unchanging monitor block pattern as a deadlock.
// On detection it latches a snapshot, emits one report word (valid/ready), then holds a sticky flag until cleared.
module postage_filter_hls_deadlock_reporter #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_MON-1:0]          block_sigs,
  input  logic                        deadlock_clear,
  output logic                        deadlock,
  output logic                        report_valid,
  input  logic                        report_ready,
  output logic [8+IDX_W+NUM_MON-1:0]  report_data,
  output logic [CNT_W-1:0]            stable_cnt
);

  typedef enum logic [1:0] {WATCH, REPORT, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_watch;
  logic [NUM_MON-1:0] prev_q, prev_d;
  logic [NUM_MON-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]   idx_q, idx_d, low_idx;
  logic [7:0]         ev_q, ev_d;
  logic               detect;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    if (block_sigs == '0)            cnt_watch = '0;
    else if (block_sigs == prev_q)   cnt_watch = cnt_q + CNT_ONE;
    else                             cnt_watch = CNT_ONE;
    detect = (state_q == WATCH) && (cnt_watch == CNT_THR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WATCH;
      cnt_q   <= '0;
      prev_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      ev_q    <= ev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    ev_d    = ev_q;
    case (state_q)
      WATCH: begin
        cnt_d  = cnt_watch;
        prev_d = block_sigs;
        if (detect) begin
          state_d = REPORT;
          pat_d   = block_sigs;
          idx_d   = low_idx;
          ev_d    = (ev_q == 8'hFF) ? ev_q : ev_q + 8'd1;
        end
      end
      // Count and pattern history are frozen while the report is outstanding.
      REPORT: begin
        if (report_ready) state_d = HOLD;
      end
      HOLD: begin
        cnt_d  = '0;
        prev_d = '0;
        if (deadlock_clear) state_d = WATCH;
      end
      default: state_d = WATCH;
    endcase
  end

  always_comb begin
    deadlock     = (state_q != WATCH);
    report_valid = (state_q == REPORT);
    report_data  = {ev_q, idx_q, pat_q};
    stable_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_postage_filter_hls_deadlock_reporter.sv
// Bench for the deadlock reporter: directed scenarios plus random traffic against a run-length reference model.
module tb_postage_filter_hls_deadlock_reporter;

  localparam int NM  = 4;
  localparam int IW  = 2;
  localparam int THR = 8;
  localparam int CW  = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NM-1:0]  block_sigs = '0;
  logic           deadlock_clear = 1'b0;
  logic           report_ready = 1'b0;
  logic           deadlock, report_valid;
  logic [8+IW+NM-1:0] report_data;
  logic [CW-1:0]  stable_cnt;

  postage_filter_hls_deadlock_reporter #(.NUM_MON(NM), .IDX_W(IW), .THRESH(THR), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .block_sigs(block_sigs), .deadlock_clear(deadlock_clear),
    .deadlock(deadlock), .report_valid(report_valid), .report_ready(report_ready),
    .report_data(report_data), .stable_cnt(stable_cnt)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a run length of identical nonzero samples plus a phase
  // (watching / report outstanding / latched) and the last captured report.
  int            m_run;
  logic [NM-1:0] m_last;
  int            m_phase;
  logic [NM-1:0] m_pat;
  int            m_idx;
  int            m_ev;

  wire [31:0] dut_vec = {deadlock, report_valid, report_data, stable_cnt};

  function automatic logic [31:0] exp_vec();
    logic [7:0] e8;
    logic [1:0] i2;
    logic [15:0] r16;
    e8  = m_ev[7:0];
    i2  = m_idx[1:0];
    r16 = m_run[15:0];
    return {m_phase != 0, m_phase == 1, e8, i2, m_pat, r16};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_run = 0; m_last = '0; m_phase = 0; m_pat = '0; m_idx = 0; m_ev = 0;
    end else if (m_phase == 0) begin
      if (block_sigs == '0) begin
        m_run = 0; m_last = '0;
      end else if (block_sigs == m_last) begin
        m_run = m_run + 1;
      end else begin
        m_run = 1; m_last = block_sigs;
      end
      if (m_run == THR) begin
        m_pat = block_sigs;
        m_idx = -1;
        for (int i = 0; i < NM; i++) if (block_sigs[i] && m_idx < 0) m_idx = i;
        m_ev = (m_ev < 255) ? m_ev + 1 : 255;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (report_ready) m_phase = 2;
    end else begin
      m_run = 0; m_last = '0;
      if (deadlock_clear) m_phase = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (dut_vec !== 32'h0) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %h want %h", i, dut_vec, 32'h0);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_detect_basic();
    block_sigs = 4'b0100; report_ready = 1'b0;
    for (int i = 0; i < THR; i++) begin
      step();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL basic edge%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if ({deadlock, report_valid, report_data} !== {2'b11, 8'd1, 2'd2, 4'b0100}) begin
      n_err++;
      $display("FAIL basic_report: got %b_%b_%h want 1_1_%h", deadlock, report_valid, report_data, {8'd1, 2'd2, 4'b0100});
    end
    report_ready = 1'b1; step(); report_ready = 1'b0;
    deadlock_clear = 1'b1; step(); deadlock_clear = 1'b0;
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL basic_clear: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pattern_change();
    for (int i = 0; i < 5 + THR; i++) begin
      block_sigs = (i < 5) ? 4'b0100 : 4'b0110;
      step();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL change cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 5 && stable_cnt !== 16'd1) begin
        n_err++;
        $display("FAIL change_restart: got %0d want 1", stable_cnt);
      end
    end
    n_vec++;
    if (report_data[5:0] !== {2'd1, 4'b0110} || deadlock !== 1'b1) begin
      n_err++;
      $display("FAIL change_report: got dl=%b %h want dl=1 idx/pat %h", deadlock, report_data[5:0], {2'd1, 4'b0110});
    end
    report_ready = 1'b1; step(); report_ready = 1'b0;
    deadlock_clear = 1'b1; step(); deadlock_clear = 1'b0;
  endtask

  task automatic test_no_partial();
    int peak;
    bit seen_dl;
    peak = 0; seen_dl = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < THR; i++) begin
        block_sigs = (i < THR - 1) ? 4'b0001 : 4'b0000;
        step();
        n_vec++;
        if (dut_vec !== exp_vec()) begin
          n_err++;
          $display("FAIL nopartial r%0d c%0d: got %h want %h", r, i, dut_vec, exp_vec());
        end
        if (int'(stable_cnt) > peak) peak = int'(stable_cnt);
        if (deadlock) seen_dl = 1;
      end
    end
    n_vec++;
    if (peak != THR - 1 || seen_dl || stable_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL nopartial_peak: got peak=%0d dl=%b cnt=%0d want %0d/0/0", peak, seen_dl, stable_cnt, THR - 1);
    end
  endtask

  task automatic test_backpressure();
    reset = 1'b1; step(); reset = 1'b0;
    block_sigs = 4'b1000; report_ready = 1'b0;
    for (int i = 0; i < THR + 10; i++) begin
      deadlock_clear = (i >= THR) && (i % 2 == 0);
      if (i >= THR) block_sigs = 4'($urandom);
      step();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL backpressure cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    deadlock_clear = 1'b0;
    n_vec++;
    if ({report_valid, report_data} !== {1'b1, 8'd1, 2'd3, 4'b1000}) begin
      n_err++;
      $display("FAIL bp_hold: got %b %h want 1 %h", report_valid, report_data, {8'd1, 2'd3, 4'b1000});
    end
    report_ready = 1'b1; step(); report_ready = 1'b0;
    deadlock_clear = 1'b1; step(); deadlock_clear = 1'b0;
    block_sigs = 4'b1010;
    for (int i = 0; i < THR; i++) step();
    n_vec++;
    if ({deadlock, report_data} !== {1'b1, 8'd2, 2'd1, 4'b1010} || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL bp_second: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_report();
    n_vec++;
    if (report_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: got valid=%b want 1", report_valid);
    end
    reset = 1'b1; report_ready = 1'b1; step(); reset = 1'b0; report_ready = 1'b0;
    n_vec++;
    if (dut_vec !== 32'h0 || exp_vec() !== 32'h0) begin
      n_err++;
      $display("FAIL midrst: got %h want 0", dut_vec);
    end
    block_sigs = 4'b0000; step();
  endtask

  task automatic test_back_to_back();
    int vcyc;
    vcyc = 0;
    report_ready = 1'b1; block_sigs = 4'b0010;
    for (int i = 0; i < THR + 8; i++) begin
      if (i >= THR + 1) block_sigs = 4'($urandom_range(1, 15));
      step();
      if (report_valid) vcyc++;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (vcyc != 1 || stable_cnt !== 16'd0 || deadlock !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_once: got valid_cycles=%0d cnt=%0d dl=%b want 1/0/1", vcyc, stable_cnt, deadlock);
    end
    report_ready = 1'b0;
    deadlock_clear = 1'b1; step(); deadlock_clear = 1'b0;
  endtask

  task automatic test_random();
    logic [NM-1:0] cur;
    cur = 4'b0011;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 7) cur = 4'($urandom);
      block_sigs     = cur;
      report_ready   = ($urandom_range(0, 3) == 0);
      deadlock_clear = ($urandom_range(0, 5) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      step();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; deadlock_clear = 1'b0; report_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_detect_basic();
    test_pattern_change();
    test_no_partial();
    test_backpressure();
    test_reset_mid_report();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
